// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic vector-pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int DEF_CTRL_W = 6;
  localparam int DEF_DATA_W = 92;
  localparam int DEF_CNT_W  = 16;

  localparam int CTRL_PCSRC = 0;
  localparam int CTRL_SWR   = 1;
  localparam int CTRL_VWR   = 2;
  localparam int CTRL_HWR   = 3;
  localparam int CTRL_M2R   = 4;
  localparam int CTRL_MWR   = 5;

  // True when a control word would commit any architectural write downstream.
  function automatic logic ctrl_commits(input logic [DEF_CTRL_W-1:0] ctrl);
    return ctrl[CTRL_SWR] | ctrl[CTRL_VWR] | ctrl[CTRL_HWR] |
           ctrl[CTRL_MWR] | ctrl[CTRL_M2R] | ctrl[CTRL_PCSRC];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, flush-to-bubble, and saturating stall/bubble statistics.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  skid_state_t       state_q;
  skid_state_t       state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic accept;
  logic drain;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;

  // A flush cycle discards the incoming beat even when in_ready is high.
  assign accept    = in_valid & in_ready_q & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign drain     = out_valid & out_ready;

  assign in_ready  = in_ready_q;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state_q;

  // Next-state and register-steering decisions for the EMPTY/ONE/FULL buffer.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d      = FULL;
            load_skid_in = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register; in_ready is registered from the next state so it never
  // depends combinationally on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Main and skid storage; flush zeroes control bits but leaves payload alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid_in) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .clr   (clr_stats),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~out_valid),
    .clr   (clr_stats),
    .cnt   (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; a second instance with
// 3-bit counters shares the stimulus to exercise saturation.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 6;
  localparam int DATA_W = 92;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              clr_stats = 1'b0;
  logic              in_valid = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_ready = 1'b0;

  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_occupancy;
  logic [SAT_W-1:0]  s_stall_cnt;
  logic [SAT_W-1:0]  s_bubble_cnt;

  int tests_run = 0;
  int fail_count = 0;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .clr_stats  (clr_stats),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(SAT_W)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .clr_stats  (clr_stats),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (s_out_ctrl),
    .out_data   (s_out_data),
    .occupancy  (s_occupancy),
    .stall_cnt  (s_stall_cnt),
    .bubble_cnt (s_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    tests_run++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic rdy,
                               input logic fl, input logic clr);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    clr_stats = clr;
    tick();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_ctrl", out_ctrl, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_bubble_cnt", bubble_cnt, 0);
    reset = 1'b0;

    // Bubble: five idle cycles
    for (int i = 1; i <= 5; i++) begin
      idle(1'b0);
      checkOutput($sformatf("bub_ctrl_%0d", i), out_ctrl, 0);
      checkOutput($sformatf("bub_cnt_%0d", i), bubble_cnt, i);
    end

    // Streaming: beats 1..4 with out_ready held high
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    checkOutput("clr_bubble", bubble_cnt, 0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("str_valid_%0d", i), out_valid, 1);
      checkOutput($sformatf("str_data_%0d", i), out_data, i);
      checkOutput($sformatf("str_ctrl_%0d", i), out_ctrl, i);
      checkOutput($sformatf("str_occ_%0d", i), occupancy, 1);
      checkOutput($sformatf("str_rdy_%0d", i), in_ready, 1);
    end
    idle(1'b1);
    checkOutput("str_drained", out_valid, 0);
    checkOutput("str_stall", stall_cnt, 0);
    checkOutput("str_bubble", bubble_cnt, 1);

    // Backpressure: A, B, C with out_ready low
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 6'h02, 92'hA, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_a_occ", occupancy, 1);
    checkOutput("bp_a_rdy", in_ready, 1);
    applyStimulus(1'b1, 6'h04, 92'hB, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_b_occ", occupancy, 2);
    checkOutput("bp_b_rdy", in_ready, 0);
    checkOutput("bp_b_data", out_data, 92'hA);
    applyStimulus(1'b1, 6'h08, 92'hC, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h08, 92'hC, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_hold_occ", occupancy, 2);
    checkOutput("bp_hold_data", out_data, 92'hA);
    checkOutput("bp_hold_ctrl", out_ctrl, 6'h02);
    checkOutput("bp_stall3", stall_cnt, 3);
    applyStimulus(1'b1, 6'h08, 92'hC, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_out_b", out_data, 92'hB);
    checkOutput("bp_out_b_ctrl", out_ctrl, 6'h04);
    checkOutput("bp_out_b_occ", occupancy, 1);
    checkOutput("bp_out_b_rdy", in_ready, 1);
    applyStimulus(1'b1, 6'h08, 92'hC, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_out_c", out_data, 92'hC);
    checkOutput("bp_out_c_ctrl", out_ctrl, 6'h08);
    idle(1'b1);
    checkOutput("bp_empty", occupancy, 0);
    checkOutput("bp_stall_final", stall_cnt, 3);

    // Flush while FULL with an all-ones control beat presented
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 6'h01, 92'hD, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h01, 92'hE, 1'b0, 1'b0, 1'b0);
    checkOutput("fl_pre_occ", occupancy, 2);
    applyStimulus(1'b1, 6'h3F, 92'hF, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_valid", out_valid, 0);
    checkOutput("fl_ctrl", out_ctrl, 0);
    checkOutput("fl_occ", occupancy, 0);
    checkOutput("fl_rdy", in_ready, 1);
    checkOutput("fl_stall", stall_cnt, 2);
    idle(1'b1);
    checkOutput("fl_no_ghost", out_valid, 0);
    applyStimulus(1'b1, 6'h02, 92'h6, 1'b1, 1'b0, 1'b0);
    checkOutput("fl_next_data", out_data, 92'h6);
    checkOutput("fl_next_ctrl", out_ctrl, 6'h02);
    idle(1'b1);

    // Saturation on the 3-bit-counter instance
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 6'h02, 92'h7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idle(1'b0);
    checkOutput("sat_stall7", s_stall_cnt, 7);
    checkOutput("sat_wide_stall10", stall_cnt, 10);
    idle(1'b0);
    checkOutput("sat_stall_stays", s_stall_cnt, 7);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat_clr", s_stall_cnt, 0);
    idle(1'b1);

    // Asynchronous reset while FULL
    applyStimulus(1'b1, 6'h10, 92'h8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'h20, 92'h9, 1'b0, 1'b0, 1'b0);
    checkOutput("ar_pre_occ", occupancy, 2);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_valid", out_valid, 0);
    checkOutput("ar_ctrl", out_ctrl, 0);
    checkOutput("ar_occ", occupancy, 0);
    checkOutput("ar_stall", stall_cnt, 0);
    checkOutput("ar_bubble", bubble_cnt, 0);
    checkOutput("ar_rdy", in_ready, 1);
    tick();
    reset = 1'b0;
    idle(1'b1);
    checkOutput("ar_after_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
